// File: rtl/pulse_meter.sv
// pulse_meter: measures pulseIn high time in whole ms, rounded, with a valid strobe.
// Optional input deglitch filter enabled by defining PULSE_METER_DEGLITCH_EN.
`ifndef MASTER_CLK_CYC_PER_MS
`define MASTER_CLK_CYC_PER_MS 10
`endif

module pulse_meter #(
  parameter int CYC_PER_MS   = `MASTER_CLK_CYC_PER_MS,
  parameter int DEGLITCH_CYC = 4
) (
  input  logic       masterClk,
  input  logic       rst,
  input  logic       pulseIn,
  output logic [7:0] pulseLength,
  output logic       lengthValid,
  output logic       overflow,
  output logic       busy
);

  localparam int CW = $clog2(CYC_PER_MS);
  localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_MS - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(CYC_PER_MS / 2);
  localparam logic [8:0]    MS_SAT   = 9'd256;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    REPORT
  } state_t;

  logic          sync1;
  logic          in_s;
  logic          lvl;
  logic          prev;
  logic          rise;
  logic          fall;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] cyc_nxt;
  logic [8:0]    ms_cnt;
  logic [8:0]    ms_nxt;
  logic          report;
  logic          round_up;
  logic [8:0]    rnd;
  logic          sat;

  // Two-flop synchroniser; idles high so a level held through reset is ignored
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      in_s  <= 1'b1;
    end else begin
      sync1 <= pulseIn;
      in_s  <= sync1;
    end
  end

`ifdef PULSE_METER_DEGLITCH_EN
  localparam int GW = $clog2(DEGLITCH_CYC + 1);
  localparam logic [GW-1:0] GLT_LAST = GW'(DEGLITCH_CYC - 1);

  logic [GW-1:0] glt_cnt;

  // Filtered level follows in_s only after DEGLITCH_CYC consecutive differing cycles
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      lvl     <= 1'b1;
      glt_cnt <= '0;
    end else if (in_s == lvl) begin
      glt_cnt <= '0;
    end else if (glt_cnt == GLT_LAST) begin
      lvl     <= in_s;
      glt_cnt <= '0;
    end else begin
      glt_cnt <= glt_cnt + 1'b1;
    end
  end
`else
  logic unused_dg;
  assign unused_dg = |DEGLITCH_CYC;
  assign lvl = in_s;
`endif

  // Edge register: previous filtered level, reset high like the synchroniser
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= lvl;
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  // State and counter registers
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      ms_cnt  <= ms_nxt;
    end
  end

  // Next state: count high cycles, wrap per ms, saturate ms at 256
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    ms_nxt    = ms_cnt;
    report    = 1'b0;
    unique case (state)
      IDLE, REPORT: begin
        if (rise) begin
          state_nxt = MEASURE;
          cyc_nxt   = CW'(1);
          ms_nxt    = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_nxt = REPORT;
          report    = 1'b1;
        end else if (lvl) begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_nxt = '0;
            if (ms_cnt != MS_SAT) ms_nxt = ms_cnt + 9'd1;
          end else begin
            cyc_nxt = cyc_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign round_up = (cyc_cnt >= CYC_HALF);
  assign rnd      = ms_cnt + {8'd0, round_up};
  assign sat      = rnd[8];
  assign busy     = (state == MEASURE);

  // Result registers: loaded on the fall, visible with the strobe in REPORT
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      pulseLength <= '0;
      overflow    <= 1'b0;
      lengthValid <= 1'b0;
    end else begin
      lengthValid <= report;
      if (report) begin
        pulseLength <= sat ? 8'hFF : rnd[7:0];
        overflow    <= sat;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: random and directed pulses against a rounding reference model.
// Define PULSE_METER_DEGLITCH_EN to also exercise the input filter.
module tb_pulse_meter;

  localparam int CPM = 10;
`ifdef PULSE_METER_DEGLITCH_EN
  localparam int DG = 4;
`else
  localparam int DG = 0;
`endif
  localparam int LAT   = 4 + DG;
  localparam int MINLO = (DG > 1) ? DG : 1;
  localparam int MINHI = (DG > 1) ? DG : 1;

  typedef struct {
    int len;
    int ovf;
    int fall;
  } rep_t;

  logic       masterClk = 1'b0;
  logic       rst;
  logic       pulseIn;
  logic [7:0] pulseLength;
  logic       lengthValid;
  logic       overflow;
  logic       busy;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  rep_t exp_q[$];
  rep_t mon_e;

  pulse_meter #(
    .CYC_PER_MS  (CPM),
    .DEGLITCH_CYC(4)
  ) dut (
    .masterClk  (masterClk),
    .rst        (rst),
    .pulseIn    (pulseIn),
    .pulseLength(pulseLength),
    .lengthValid(lengthValid),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 masterClk = ~masterClk;

  always @(posedge masterClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: C high cycles -> nearest ms, clipped at 255 with overflow
  function automatic rep_t model(input int c, input int f);
    rep_t m;
    int   r;
    r = c / CPM + (((c % CPM) >= CPM / 2) ? 1 : 0);
    m.len  = (r > 255) ? 255 : r;
    m.ovf  = (r > 255) ? 1 : 0;
    m.fall = f;
    return m;
  endfunction

  task automatic step();
    @(posedge masterClk);
    #1;
  endtask

  task automatic pulse(input int h, input int l, input bit rep);
    rep_t e;
    pulseIn = 1'b1;
    repeat (h - 1) step();
    @(negedge masterClk);
    if (h >= 4 + DG) chk("busy_hi", busy, 1);
    step();
    pulseIn = 1'b0;
    if (rep) begin
      e = model(h, cyc);
      exp_q.push_back(e);
    end
    repeat (l) step();
    if (l >= 4 + DG) begin
      @(negedge masterClk);
      chk("busy_lo", busy, 0);
    end
  endtask

  // Strobe monitor; latency counted inclusively from the raw-fall cycle
  always @(negedge masterClk) begin
    if (rst === 1'b0 && lengthValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("stray_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("len", int'(pulseLength), mon_e.len);
        chk("ovf", int'(overflow), mon_e.ovf);
        chk("lat", cyc - mon_e.fall + 1, LAT);
      end
    end
  end

  initial begin
    int   h;
    int   l;
    bit   seen;
    rep_t e;

    rst     = 1'b1;
    pulseIn = 1'b0;
    repeat (3) @(posedge masterClk);
    @(negedge masterClk);
    chk("rst_len", int'(pulseLength), 0);
    chk("rst_valid", int'(lengthValid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    repeat (8) step();

    pulse(50, 12, 1);
    pulse(54, 12, 1);
    pulse(55, 12, 1);
    pulse(MINHI > 4 ? MINHI : 4, 12, 1);

    pulse(2550, 12, 1);
    pulse(2560, 12, 1);
    pulse(3000, 12, 1);
    pulse(20, 12, 1);

    pulse(20, MINLO, 1);
    pulse(40, 12, 1);

    pulseIn = 1'b1;
    repeat (30) step();
    rst = 1'b1;
    @(negedge masterClk);
    chk("mid_rst_len", int'(pulseLength), 0);
    chk("mid_rst_valid", int'(lengthValid), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_busy", int'(busy), 0);
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    pulseIn = 1'b0;
    repeat (12) step();
    chk("held_busy", int'(busy), 0);
    pulse(30, 12, 1);

`ifdef PULSE_METER_DEGLITCH_EN
    seen    = 1'b0;
    pulseIn = 1'b1;
    repeat (3) step();
    pulseIn = 1'b0;
    repeat (12) begin
      @(negedge masterClk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy", int'(seen), 0);
    step();

    pulseIn = 1'b1;
    repeat (28) step();
    pulseIn = 1'b0;
    repeat (3) step();
    pulseIn = 1'b1;
    repeat (29) step();
    pulseIn = 1'b0;
    e.len  = 6;
    e.ovf  = 0;
    e.fall = cyc;
    exp_q.push_back(e);
    repeat (16) step();

    pulse(50, 16, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) h = $urandom_range(3100, 2400);
      else                        h = $urandom_range(150, MINHI);
      l = $urandom_range(20, MINLO);
      pulse(h, l, 1);
    end

    repeat (20 + DG) step();
    chk("pending", exp_q.size(), 0);
    chk("busy_end", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
